mac_sequencer: RTL and testbench

Control stage directly upstream of one floating-point multiply-accumulate compute unit in the matrix multiplier. It takes paired A/B operand streams, runs one dot product of run-time length `k_len`, and presents operands to the unit one pair at a time. For each pair it drives the unit's multiply, add and output-register enables at fixed phases matching the multiplier and adder latencies. It also collects the unit's overflow flag into a sticky error and pulses `done` when the dot product is complete.

---
 rtl/mm_pkg.sv | 14 +
 rtl/mac_sequencer_if.sv | 26 ++
 rtl/mac_phase_timer.sv | 55 +++++
 rtl/mac_sequencer.sv | 112 +++++++++++
 tb/tb_mac_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Types and defaults shared by the MAC sequencer, its operand interface and the phase timer.
package mm_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCEPT,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Paired A/B operand streams feeding the MAC sequencer.
// A and B transfer together only when both sides are valid.
interface mac_sequencer_if
  import mm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/mac_phase_timer.sv
// Phase counter for one multiply-accumulate step.
// A go pulse starts the count at phase 0 on the next cycle. The enables are
// decoded from the registered phase, so an asynchronous reset kills any
// pulse that is still pending.
module mac_phase_timer #(
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  output logic mult_en,
  output logic add_en,
  output logic out_en,
  output logic last,
  output logic post_mul
);

  localparam int P_MUL = 0;
  localparam int P_ADD = MUL_LAT;
  localparam int P_OUT = MUL_LAT + ADD_LAT;
  localparam int PW    = $clog2(P_OUT + 1);

  localparam logic [PW-1:0] P_MUL_W = PW'(P_MUL);
  localparam logic [PW-1:0] P_ADD_W = PW'(P_ADD);
  localparam logic [PW-1:0] P_OUT_W = PW'(P_OUT);

  logic          active;
  logic [PW-1:0] phase;

  // Phase counter: runs 0..P_OUT once per go pulse, then parks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      phase  <= '0;
    end else if (go) begin
      active <= 1'b1;
      phase  <= '0;
    end else if (active) begin
      if (phase == P_OUT_W) begin
        active <= 1'b0;
        phase  <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  assign mult_en  = active && (phase == P_MUL_W);
  assign add_en   = active && (phase == P_ADD_W);
  assign out_en   = active && (phase == P_OUT_W);
  assign last     = active && (phase == P_OUT_W);
  assign post_mul = active && (phase != P_MUL_W);

endmodule

// File: rtl/mac_sequencer.sv
// Control stage in front of one floating-point MAC unit: runs one dot product
// of run-time length, one operand pair at a time, and drives the unit's
// multiply/add/output enables at fixed phases.
//
// state  | meaning
// IDLE   | waiting for start; operands and err hold their last values
// CLEAR  | one cycle, acc_clr to the compute unit
// ACCEPT | waiting for a joint A/B transfer
// RUN    | phase timer drives mult_en/add_en/out_en for the accepted pair
// DONE   | one cycle, done pulse
module mac_sequencer
  import mm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int K_MAX   = 16,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1,
  parameter int CW      = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CW-1:0]     k_len,
  mac_sequencer_if.slave    ops,
  output logic [WIDTH-1:0]  Ain,
  output logic [WIDTH-1:0]  Bin,
  output logic              mult_en,
  output logic              add_en,
  output logic              out_en,
  output logic              acc_clr,
  input  logic              overflow_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CW-1:0] K_MAX_W = CW'(K_MAX);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] k_cap;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;
  logic          post_mul;

  assign accept      = (state == ACCEPT) && ops.a_valid && ops.b_valid;
  assign ops.a_ready = (state == ACCEPT) && ops.b_valid;
  assign ops.b_ready = (state == ACCEPT) && ops.a_valid;

  mac_phase_timer #(
    .MUL_LAT (MUL_LAT),
    .ADD_LAT (ADD_LAT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .go       (accept),
    .mult_en  (mult_en),
    .add_en   (add_en),
    .out_en   (out_en),
    .last     (last),
    .post_mul (post_mul)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (k_cap == '0) ? DONE : ACCEPT;
      ACCEPT:  if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = (cnt == k_cap) ? DONE : ACCEPT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Length capture, element count, operand registers and sticky overflow.
  // A start is honoured only in IDLE, so err clearing and setting never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_cap <= '0;
      cnt   <= '0;
      Ain   <= '0;
      Bin   <= '0;
      err   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        k_cap <= (k_len > K_MAX_W) ? K_MAX_W : k_len;
        cnt   <= '0;
        err   <= 1'b0;
      end
      if (accept) begin
        Ain <= ops.a_data;
        Bin <= ops.b_data;
        cnt <= cnt + 1'b1;
      end
      if (state == RUN && post_mul && overflow_in) err <= 1'b1;
    end
  end

  assign acc_clr = (state == CLEAR);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: the driver pushes the expected event
// times and operand values for each dot product, a negedge monitor pops and
// compares them whenever the DUT raises an enable, acc_clr or done.
module tb_mac_sequencer;
  import mm_pkg::*;

  localparam int WIDTH   = 32;
  localparam int K_MAX   = 16;
  localparam int MUL_LAT = 1;
  localparam int ADD_LAT = 1;
  localparam int CW      = $clog2(K_MAX + 1);
  localparam int II      = MUL_LAT + ADD_LAT + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CW-1:0]    k_len;
  logic [WIDTH-1:0] Ain, Bin;
  logic             mult_en, add_en, out_en, acc_clr;
  logic             overflow_in;
  logic             busy, done, err;

  mac_sequencer_if #(.WIDTH(WIDTH)) ops ();

  mac_sequencer #(
    .WIDTH(WIDTH), .K_MAX(K_MAX), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .ops(ops),
    .Ain(Ain), .Bin(Bin), .mult_en(mult_en), .add_en(add_en), .out_en(out_en),
    .acc_clr(acc_clr), .overflow_in(overflow_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } mul_exp_t;
  typedef struct { int cyc; logic e; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } done_exp_t;

  mul_exp_t  mul_q[$];
  int        add_q[$];
  int        out_q[$];
  int        clr_q[$];
  done_exp_t done_q[$];
  mul_exp_t  me;
  done_exp_t de;
  int        ev;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] last_a = '0;
  logic [WIDTH-1:0] last_b = '0;
  logic [WIDTH-1:0] dir_a[K_MAX];
  logic [WIDTH-1:0] dir_b[K_MAX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mult_en) begin
      if (mul_q.size() == 0) check("mult_en extra", 64'(mult_en), 0);
      else begin
        me = mul_q.pop_front();
        check("mult_en cycle", cyc, me.cyc);
        check("Ain", Ain, me.a);
        check("Bin", Bin, me.b);
      end
    end
    if (add_en) begin
      if (add_q.size() == 0) check("add_en extra", 64'(add_en), 0);
      else begin ev = add_q.pop_front(); check("add_en cycle", cyc, ev); end
    end
    if (out_en) begin
      if (out_q.size() == 0) check("out_en extra", 64'(out_en), 0);
      else begin ev = out_q.pop_front(); check("out_en cycle", cyc, ev); end
    end
    if (acc_clr) begin
      if (clr_q.size() == 0) check("acc_clr extra", 64'(acc_clr), 0);
      else begin
        ev = clr_q.pop_front();
        check("acc_clr cycle", cyc, ev);
        check("err cleared by start", err, 0);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done extra", 64'(done), 0);
      else begin
        de = done_q.pop_front();
        check("done cycle", cyc, de.cyc);
        check("err at done", err, de.e);
        check("Ain at done", Ain, de.a);
        check("Bin at done", Bin, de.b);
        check("busy at done", busy, 1);
      end
    end
  end

  // One dot product. Offsets are cycles after the cycle start is driven.
  // ovf_off/glitch_off: -1 none, -2 pick at random.
  task automatic run_job(input int k, input int stall, input bit stall_a,
                         input int ovf_off, input int glitch_off, input bit use_dir);
    int s, n, done_off, acc, j, ovf, glitch;
    bit err_exp, in_stall;
    logic [WIDTH-1:0] pa[$];
    logic [WIDTH-1:0] pb[$];
    s = cyc;
    n = (k > K_MAX) ? K_MAX : k;
    if (n == 0) stall = 0;
    for (int i = 0; i < n; i++) begin
      pa.push_back(use_dir ? dir_a[i] : WIDTH'($urandom()));
      pb.push_back(use_dir ? dir_b[i] : WIDTH'($urandom()));
    end
    done_off = 2 + n * II + stall;
    ovf = (ovf_off == -2) ? int'($urandom_range(1, done_off)) : ovf_off;
    glitch = glitch_off;
    if (glitch_off == -2)
      glitch = (n > 0) ? 2 + stall + II * int'($urandom_range(0, n - 1)) + int'($urandom_range(1, II - 1)) : -1;

    // Expected schedule: pair i is accepted at 2+stall+i*II, then enables follow.
    err_exp = 1'b0;
    clr_q.push_back(s + 1);
    for (int i = 0; i < n; i++) begin
      acc = 2 + stall + i * II;
      mul_q.push_back('{s + acc + 1, pa[i], pb[i]});
      add_q.push_back(s + acc + 1 + MUL_LAT);
      out_q.push_back(s + acc + 1 + MUL_LAT + ADD_LAT);
      if (ovf > acc + 1 && ovf <= acc + 1 + MUL_LAT + ADD_LAT) err_exp = 1'b1;
    end
    if (n > 0) begin
      last_a = pa[n-1];
      last_b = pb[n-1];
    end
    done_q.push_back('{s + done_off, err_exp, last_a, last_b});

    check("busy in idle", busy, 0);
    for (int t = 0; t <= done_off; t++) begin
      start       = (t == 0) || (t == glitch);
      k_len       = (t == 0) ? CW'(k) : CW'($urandom_range(0, 31));
      overflow_in = (t == ovf);
      in_stall    = (stall > 0) && (t >= 2) && (t < 2 + stall);
      ops.a_valid = !(in_stall && stall_a);
      ops.b_valid = !(in_stall && !stall_a);
      j = 0;
      for (int i = 0; i < n; i++) if (2 + stall + i * II < t) j++;
      if (n > 0) begin
        ops.a_data = pa[(j < n) ? j : n - 1];
        ops.b_data = pb[(j < n) ? j : n - 1];
      end else begin
        ops.a_data = WIDTH'($urandom());
        ops.b_data = WIDTH'($urandom());
      end
      if (in_stall) begin
        #1;
        check("a_ready in stall", ops.a_ready, stall_a);
        check("b_ready in stall", ops.b_ready, !stall_a);
      end
      @(negedge clk);
    end
    start       = 1'b0;
    overflow_in = 1'b0;
    ops.a_valid = 1'b0;
    ops.b_valid = 1'b0;
  endtask

  // Reset asserted during RUN phase 1 of the first product of a 3-long run.
  task automatic reset_mid_run();
    int s;
    s = cyc;
    start = 1'b1;
    k_len = CW'(3);
    ops.a_valid = 1'b1;
    ops.b_valid = 1'b1;
    ops.a_data  = WIDTH'($urandom());
    ops.b_data  = WIDTH'($urandom());
    clr_q.push_back(s + 1);
    mul_q.push_back('{s + 3, ops.a_data, ops.b_data});
    add_q.push_back(s + 4);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst Ain", Ain, 0);
    check("rst Bin", Bin, 0);
    check("rst enables", {mult_en, add_en, out_en, acc_clr}, 0);
    check("rst busy/done/err", {busy, done, err}, 0);
    check("rst ready", {ops.a_ready, ops.b_ready}, 0);
    ops.a_valid = 1'b0;
    ops.b_valid = 1'b0;
    last_a = '0;
    last_b = '0;
    repeat (3) @(negedge clk);
    check("no events pending after reset", mul_q.size() + add_q.size() + clr_q.size(), 0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    k_len = '0;
    overflow_in = 1'b0;
    ops.a_valid = 1'b0;
    ops.b_valid = 1'b0;
    ops.a_data  = '0;
    ops.b_data  = '0;
    repeat (2) @(negedge clk);
    check("reset Ain", Ain, 0);
    check("reset Bin", Bin, 0);
    check("reset status", {busy, done, err, mult_en, add_en, out_en, acc_clr}, 0);
    reset = 1'b1;
    @(negedge clk);

    dir_a[0] = 32'h3f800000; dir_a[1] = 32'h40000000; dir_a[2] = 32'h40400000;
    dir_b[0] = 32'h40800000; dir_b[1] = 32'h40a00000; dir_b[2] = 32'h40c00000;
    run_job(3, 0, 1'b0, -1, -1, 1'b1);
    run_job(2, 5, 1'b0, -1, -1, 1'b0);
    run_job(2, 3, 1'b1, -1, -1, 1'b0);
    run_job(0, 0, 1'b0, -1, -1, 1'b0);
    run_job(3, 0, 1'b0, 2 + II + MUL_LAT + ADD_LAT + 1, -1, 1'b0);
    run_job(1, 0, 1'b0, -1, -1, 1'b0);
    reset_mid_run();
    run_job(1, 0, 1'b0, -1, -1, 1'b0);
    run_job(20, 0, 1'b0, -1, 2 + 1 + MUL_LAT, 1'b0);
    for (int r = 0; r < 30; r++)
      run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'(($urandom() & 1)),
              ($urandom_range(0, 3) == 0) ? -1 : -2, ($urandom_range(0, 1) == 0) ? -1 : -2, 1'b0);

    repeat (2) @(negedge clk);
    check("pending expectations", mul_q.size() + add_q.size() + out_q.size() + clr_q.size() + done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
